neuron_mac_acc: RTL and testbench

// - One hidden-layer neuron datapath for the 8x8 handwritten-digit ANN.
// - Each cycle takes a 16-lane chunk of pixels and weights and forms a 16-way dot product (mac_out).
// - Accumulates 4 chunks (64 pixels) plus a bias into one 22-bit neuron pre-activation.
// - Sits between the pixel/weight memories and the activation stage or next layer.

---
 rtl/neuron_pkg.sv | 15 +
 rtl/neuron_dot16.sv | 71 +++++++
 rtl/neuron_mac_acc.sv | 65 ++++++
 tb/tb_neuron_mac_acc.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// neuron_pkg: shared widths and types for the 64-input hidden-layer neuron datapath.
package neuron_pkg;
    localparam int LANES  = 16;
    localparam int PIX_W  = 8;
    localparam int WGT_W  = 8;
    localparam int CHUNKS = 4;
    localparam int ACC_W  = 22;
    localparam int FRAC   = 12;
    localparam int PROD_W = PIX_W + WGT_W;
    localparam int MAC_W  = PROD_W + $clog2(LANES);
    localparam int CNT_W  = $clog2(CHUNKS);
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [MAC_W-1:0]  mac_t;
    typedef logic signed [ACC_W-1:0]  acc_t;
endpackage

// File: rtl/neuron_dot16.sv
// neuron_dot16: registered 16-lane unsigned-pixel x signed-weight products, then a registered
// adder tree; chunk tags and bias ride alongside so bubbles never mix up chunks.
module neuron_dot16 import neuron_pkg::*; (
    input  logic                     clk,
    input  logic                     reset_accum_n,
    input  logic                     in_valid,
    input  logic                     first,
    input  logic                     last,
    input  logic [WGT_W-1:0]         bias,
    input  logic [LANES*PIX_W-1:0]   pixels,
    input  logic [LANES*WGT_W-1:0]   weights,
    output logic signed [MAC_W-1:0]  mac_out,
    output logic                     mac_valid,
    output logic                     mac_first,
    output logic                     mac_last,
    output logic signed [ACC_W-1:0]  mac_bias
);
    prod_t prod_d [LANES];
    prod_t prod [LANES];
    mac_t  sum;
    logic  v1, f1, l1;
    acc_t  b1;

    always_comb begin
        for (int i = 0; i < LANES; i++)
            prod_d[i] = prod_t'($signed({1'b0, pixels[i*PIX_W +: PIX_W]})) *
                        prod_t'($signed(weights[i*WGT_W +: WGT_W]));
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < LANES; i++)
            sum = sum + mac_t'(prod[i]);
    end

    always_ff @(posedge clk or negedge reset_accum_n) begin
        if (!reset_accum_n) begin
            prod <= '{default: '0};
            v1   <= 1'b0;
            f1   <= 1'b0;
            l1   <= 1'b0;
            b1   <= '0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                prod <= prod_d;
                f1   <= first;
                l1   <= last;
                b1   <= acc_t'($signed(bias));
            end
        end
    end

    always_ff @(posedge clk or negedge reset_accum_n) begin
        if (!reset_accum_n) begin
            mac_out   <= '0;
            mac_valid <= 1'b0;
            mac_first <= 1'b0;
            mac_last  <= 1'b0;
            mac_bias  <= '0;
        end else begin
            mac_valid <= v1;
            if (v1) begin
                mac_out   <= sum;
                mac_first <= f1;
                mac_last  <= l1;
                mac_bias  <= b1;
            end
        end
    end
endmodule

// File: rtl/neuron_mac_acc.sv
// neuron_mac_acc: 4-chunk (64-input) neuron accumulator with bias; latency 3 clocks from last chunk.
// Optional hard-sigmoid output sigmoid_out when NEURON_SIGMOID_EN is defined.
module neuron_mac_acc import neuron_pkg::*; (
    input  logic                     clk,
    input  logic                     reset_accum_n,
    input  logic                     in_valid,
    input  logic [WGT_W-1:0]         bias,
    input  logic [LANES*PIX_W-1:0]   pixels,
    input  logic [LANES*WGT_W-1:0]   weights,
    output logic signed [MAC_W-1:0]  mac_out,
    output logic signed [ACC_W-1:0]  acc_out,
    output logic                     acc_valid
`ifdef NEURON_SIGMOID_EN
    ,
    output logic [7:0]               sigmoid_out
`endif
);
    logic [CNT_W-1:0] cnt;
    logic             m_valid, m_first, m_last;
    acc_t             m_bias, accum, nxt;

    neuron_dot16 u_dot (
        .clk           (clk),
        .reset_accum_n (reset_accum_n),
        .in_valid      (in_valid),
        .first         (cnt == '0),
        .last          (cnt == CNT_W'(CHUNKS - 1)),
        .bias          (bias),
        .pixels        (pixels),
        .weights       (weights),
        .mac_out       (mac_out),
        .mac_valid     (m_valid),
        .mac_first     (m_first),
        .mac_last      (m_last),
        .mac_bias      (m_bias)
    );

    always_comb nxt = (m_first ? m_bias : accum) + acc_t'(mac_out);

    always_ff @(posedge clk or negedge reset_accum_n) begin
        if (!reset_accum_n) begin
            cnt       <= '0;
            accum     <= '0;
            acc_out   <= '0;
            acc_valid <= 1'b0;
        end else begin
            if (in_valid) cnt <= cnt + 1'b1;
            if (m_valid) accum <= nxt;
            if (m_valid && m_last) acc_out <= nxt;
            acc_valid <= m_valid && m_last;
        end
    end

`ifdef NEURON_SIGMOID_EN
    acc_t sig;

    // Slope 1/64 in FRAC fixed point, centred at 0.5 (=128).
    always_comb sig = (acc_out >>> (FRAC - 6)) + acc_t'(128);

    always_ff @(posedge clk or negedge reset_accum_n) begin
        if (!reset_accum_n) sigmoid_out <= '0;
        else sigmoid_out <= sig < 0 ? 8'd0 : sig > 255 ? 8'd255 : sig[7:0];
    end
`endif
endmodule

// File: tb/tb_neuron_mac_acc.sv
// tb_neuron_mac_acc: table-driven neuron vectors plus gap, back-to-back and mid-neuron reset sequences.
// Sigmoid checks are compiled in when NEURON_SIGMOID_EN is defined.
module tb_neuron_mac_acc;
    logic         clk = 1'b0;
    logic         reset_accum_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [7:0]   bias = '0;
    logic [127:0] pixels = '0;
    logic [127:0] weights = '0;
    logic signed [19:0] mac_out;
    logic signed [21:0] acc_out;
    logic         acc_valid;
`ifdef NEURON_SIGMOID_EN
    logic [7:0]   sigmoid_out;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct {
        string      name;
        logic [7:0] pix;
        logic [7:0] wgt;
        logic [7:0] b;
        int         mac;
        int         acc;
        int         sig;
    } vec_t;

    vec_t vecs [7];

    neuron_mac_acc dut (
        .clk           (clk),
        .reset_accum_n (reset_accum_n),
        .in_valid      (in_valid),
        .bias          (bias),
        .pixels        (pixels),
        .weights       (weights),
        .mac_out       (mac_out),
        .acc_out       (acc_out),
        .acc_valid     (acc_valid)
`ifdef NEURON_SIGMOID_EN
        ,
        .sigmoid_out   (sigmoid_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] p, input logic [7:0] w, input logic [7:0] b);
        in_valid = 1'b1;
        pixels   = {16{p}};
        weights  = {16{w}};
        bias     = b;
        tick();
        in_valid = 1'b0;
    endtask

    // Non-first chunks carry a scrambled bias that must be ignored.
    task automatic run_neuron(input vec_t v, input int gap);
        for (int c = 0; c < 4; c++) begin
            if (c == 2) repeat (gap) tick();
            drive(v.pix, v.wgt, c == 0 ? v.b : v.b ^ 8'h5A);
        end
        tick();
        check({v.name, " mac_out"}, int'(mac_out), v.mac);
        check({v.name, " acc_valid early"}, int'(acc_valid), 0);
        tick();
        check({v.name, " acc_valid"}, int'(acc_valid), 1);
        check({v.name, " acc_out"}, int'(acc_out), v.acc);
        tick();
        check({v.name, " acc_valid pulse"}, int'(acc_valid), 0);
        check({v.name, " acc_out hold"}, int'(acc_out), v.acc);
`ifdef NEURON_SIGMOID_EN
        check({v.name, " sigmoid_out"}, int'(sigmoid_out), v.sig);
`endif
    endtask

    initial begin
        vecs[0] = '{"ones",   8'h01, 8'h01, 8'd11,  16,                  75,                   129};
        vecs[1] = '{"neg1",   8'hFF, 8'hFF, 8'h00,  -4080,               -16320,               0};
        vecs[2] = '{"minwc",  8'hFF, 8'h80, 8'h80,  -16*255*128,         -64*255*128 - 128,    0};
        vecs[3] = '{"maxwc",  8'hFF, 8'h7F, 8'h7F,  16*255*127,          64*255*127 + 127,     255};
        vecs[4] = '{"zero",   8'h00, 8'h55, 8'h00,  0,                   0,                    128};
        vecs[5] = '{"biasm5", 8'h00, 8'h55, 8'hFB,  0,                   -5,                   127};
        vecs[6] = '{"mixed",  8'h0A, 8'hFD, 8'h7F,  -480,                -1793,                99};

        repeat (3) tick();
        check("reset mac_out", int'(mac_out), 0);
        check("reset acc_out", int'(acc_out), 0);
        check("reset acc_valid", int'(acc_valid), 0);
`ifdef NEURON_SIGMOID_EN
        check("reset sigmoid_out", int'(sigmoid_out), 0);
`endif
        reset_accum_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) run_neuron(vecs[i], 0);

        run_neuron('{"gap2", 8'h01, 8'h01, 8'd11, 16, 75, 129}, 2);

        // Two neurons with no bubble: A (ones, bias 11) then B (-1 x 255, bias 0).
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1;
            drive(c < 4 ? 8'h01 : 8'hFF, c < 4 ? 8'h01 : 8'hFF,
                  c == 0 ? 8'd11 : c == 4 ? 8'd0 : 8'h33);
            check($sformatf("b2b acc_valid c%0d", c), int'(acc_valid), c == 5 ? 1 : 0);
            if (c == 5) check("b2b acc_out A", int'(acc_out), 75);
        end
        tick();
        check("b2b acc_valid gap", int'(acc_valid), 0);
        tick();
        check("b2b acc_valid B", int'(acc_valid), 1);
        check("b2b acc_out B", int'(acc_out), -16320);

        // Reset in the middle of chunk 2 discards the partial neuron.
        tick();
        drive(8'h01, 8'h01, 8'd11);
        drive(8'h01, 8'h01, 8'h22);
        in_valid = 1'b1;
        #2 reset_accum_n = 1'b0;
        #1;
        check("midrst mac_out", int'(mac_out), 0);
        check("midrst acc_out", int'(acc_out), 0);
        check("midrst acc_valid", int'(acc_valid), 0);
        in_valid = 1'b0;
        repeat (2) tick();
        check("midrst held acc_out", int'(acc_out), 0);
        reset_accum_n = 1'b1;
        tick();
        run_neuron('{"postrst", 8'h01, 8'h01, 8'd11, 16, 75, 129}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
